// File: rtl/mc_pkg.sv
// mc_pkg: shared types for the multi-cycle control unit -- FSM states, opcodes,
// datapath select encodings and the bundled control-word struct.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_ERR
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       sign;
    logic       err;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Logical immediates are zero-extended; arithmetic ones sign-extended.
  function automatic logic imm_sign(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: memory request/ready handshake between the control unit
// (master) and the memory port (slave).
interface mc_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_timeout.sv
// mc_timeout: memory wait-state counter; done flags that TIMEOUT wait cycles
// have elapsed since the last clear.
module mc_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  // Saturates at TIMEOUT so a stalled count can never wrap back to "fine".
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == W'(TIMEOUT));

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM with memory wait supervision and a
// retired-instruction counter. Build option MC_JAL_EN adds the jal (0x03) sequence.
module mc_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  mc_control_if.master     bus,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             sign,
  output logic             err,
  output logic [CNT_W-1:0] instret
);

  // state  | meaning
  // FETCH  | read instruction at PC, load IR and PC+4 on ready
  // DECODE | branch target into ALUOut, dispatch on opcode
  // MEMADR | A + sext(imm) effective address
  // MEMRD  | data read at ALUOut, wait for ready
  // MEMWB  | MDR -> rt
  // MEMWR  | data write at ALUOut, wait for ready
  // EXEC   | A funct B
  // ALUWB  | ALUOut -> rd
  // IEXEC  | A op imm
  // IWB    | ALUOut -> rt
  // BRANCH | compare A/B, conditional PC load
  // JUMP   | PC <- jump target
  // JAL    | PC <- jump target, $31 <- PC
  // ERR    | illegal opcode or memory timeout, held until rst

  state_t           state_q;
  state_t           state_d;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] instret_q;
  logic             wait_en;
  logic             wait_clr;
  logic             wait_done;

  mc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (wait_clr),
    .en   (wait_en),
    .done (wait_done)
  );

  assign wait_en  = ctrl.mem_req & ~bus.mem_ready;
  assign wait_clr = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (wait_done) state_d = S_ERR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = S_EXEC;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:                            state_d = S_JAL;
`endif
          default:                           state_d = S_ERR;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (wait_done) state_d = S_ERR;
      end
      S_MEMWR: begin
        if (bus.mem_ready)  state_d = S_FETCH;
        else if (wait_done) state_d = S_ERR;
      end
      S_EXEC:  state_d = S_ALUWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        ctrl.sign      = 1'b1;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.sign      = 1'b1;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      // ALU setup is kept alive through IWB so the result path stays stable.
      S_IEXEC, S_IWB: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = imm_alu_op(opcode);
        ctrl.sign       = imm_sign(opcode);
        ctrl.reg_write  = (state_q == S_IWB);
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_ERR:   ctrl.err = 1'b1;
      default: ctrl = '0;
    endcase
    if (rst) ctrl = '0;
  end

  // An instruction retires when control returns to FETCH from any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_FETCH && state_d == S_FETCH) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign bus.mem_req   = ctrl.mem_req;
  assign bus.mem_we    = ctrl.mem_we;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_src        = ctrl.pc_src;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign sign          = ctrl.sign;
  assign err           = ctrl.err;
  assign instret       = rst ? '0 : instret_q;

endmodule
